// File: rtl/rv32i_pkg.sv
// Shared RV32I memory-stage definitions: opcodes, funct3 encodings, FSM states
// and the lane/legality helpers used by the data-memory handler.
package rv32i_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // funct3[1:0] encodes the access size for both loads and stores
  function automatic logic [3:0] byte_sel(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   byte_sel = 4'b0001 << off;
      2'b01:   byte_sel = 4'b0011 << off;
      default: byte_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (f3[1:0])
      2'b00:   lane_wdata = {4{sd[7:0]}};
      2'b01:   lane_wdata = {2{sd[15:0]}};
      default: lane_wdata = sd;
    endcase
  endfunction

  function automatic logic access_ok(input logic is_load, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic f3_ok;
    logic aligned;
    if (is_load) begin
      f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
              (f3 == F3_BU) || (f3 == F3_HU);
    end else begin
      f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    case (f3[1:0])
      2'b01:   aligned = ~off[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b1;
    endcase
    access_ok = f3_ok && aligned;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter: picks the byte/half at the access offset and
// sign- or zero-extends it according to funct3.
module load_extend
  import rv32i_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted_s;

  assign shifted_s = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    load_data_o = 32'h0000_0000;
    case (funct3_i)
      F3_B:    load_data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    load_data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_W:    load_data_o = rdata_i;
      F3_BU:   load_data_o = {24'h00_0000, shifted_s[7:0]};
      F3_HU:   load_data_o = {16'h0000, shifted_s[15:0]};
      default: load_data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem_handler.sv
// RV32I memory stage: runs one request/ack data-bus transaction per load/store,
// stalling the core until the access completes, errors out, or times out.
module data_mem_handler
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sel,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err
);

  mem_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  sel_q, sel_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        is_load_q, is_load_d;
  logic        err_q, err_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        stall_s;
  logic        is_load_s;
  logic        timeout_s;
  logic [31:0] ext_data_s;

  assign is_load_s = (opcode == OPC_LOAD);
  assign timeout_s = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  load_extend u_load_extend (
    .rdata_i     (mem_rdata),
    .offset_i    (off_q),
    .funct3_i    (funct3_q),
    .load_data_o (ext_data_s)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    is_load_d   = is_load_q;
    err_d       = err_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    stall_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i && (is_load_s || (opcode == OPC_STORE))) begin
          stall_s     = 1'b1;
          is_load_d   = is_load_s;
          funct3_d    = funct3;
          off_d       = address[1:0];
          addr_d      = {address[31:2], 2'b00};
          sel_d       = byte_sel(funct3, address[1:0]);
          wdata_d     = lane_wdata(funct3, store_data);
          load_data_d = 32'h0000_0000;
          cnt_d       = 32'h0000_0000;
          if (access_ok(is_load_s, funct3, address[1:0])) begin
            state_d = BUSY;
            rd_d    = is_load_s;
            wr_d    = ~is_load_s;
            err_d   = 1'b0;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        cnt_d   = cnt_q + 32'd1;
        // an ack arriving on the limit cycle still completes normally
        if (mem_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = DONE;
          if (is_load_q) begin
            load_data_d = ext_data_s;
          end else begin
            load_data_d = 32'h0000_0000;
          end
        end else if (timeout_s) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      load_data_q <= 32'h0000_0000;
      cnt_q       <= 32'h0000_0000;
      sel_q       <= 4'b0000;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      is_load_q   <= 1'b0;
      err_q       <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      is_load_q   <= is_load_d;
      err_q       <= err_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
    end
  end

  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_sel   = sel_q;
  // the accept-cycle stall is combinational, so mask it while reset is held
  assign stall     = stall_s & ~rst;
  assign done      = (state_q == DONE);
  assign err       = (state_q == DONE) & err_q;
  assign load_data = load_data_q;

endmodule
